// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// elaboration-time helpers.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Ceiling log2 for sizing index/count fields (value >= 2 expected).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // (base + off) mod n, used for round-robin pointer arithmetic.
   function automatic int unsigned rr_wrap(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: rotate req so last+1 sits at bit 0,
// take the lowest set bit, rotate the pick back to a requester index.
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] pick_onehot,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               any
);

   logic [NUM_REQ-1:0] rot;
   logic               found;
   int unsigned        first_k;

   always_comb begin
      rot         = '0;
      found       = 1'b0;
      first_k     = 0;
      pick_onehot = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         rot[k] = req[IDX_W'(rr_wrap(32'(last), k + 1, NUM_REQ))];
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && rot[k]) begin
            found   = 1'b1;
            first_k = k;
         end
      end
      pick_idx = IDX_W'(rr_wrap(32'(last), first_k + 1, NUM_REQ));
      if (found) begin
         pick_onehot[pick_idx] = 1'b1;
      end
      any = found;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port between
// NUM_REQ requesters; never offers a word while the FIFO reports full.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4,
   localparam int unsigned IDX_W    = clog2(NUM_REQ),
   localparam int unsigned CNT_W    = clog2(MAX_BURST + 1)
) (
   input  logic                     clock,
   input  logic                     aclr,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     fifo_wrreq,
   output logic [WIDTH-1:0]         fifo_data,
   input  logic                     fifo_wrfull,
   output logic                     busy,
   output logic [IDX_W-1:0]         owner
);

   state_t             state, state_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic               busy_n;
   logic [IDX_W-1:0]   owner_n;
   logic [IDX_W-1:0]   last, last_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [WIDTH-1:0]   words [NUM_REQ];
   logic               accept;

   fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req         (req),
      .last        (last),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .any         (pick_any)
   );

   // Unpack the flat request data bus into per-requester words.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         words[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state <= ST_IDLE;
         gnt   <= '0;
         busy  <= 1'b0;
         owner <= '0;
         last  <= IDX_W'(NUM_REQ - 1);
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         busy  <= busy_n;
         owner <= owner_n;
         last  <= last_n;
         cnt   <= cnt_n;
      end
   end

   // Next state plus the combinational write-port outputs.
   always_comb begin
      state_n    = state;
      gnt_n      = gnt;
      busy_n     = busy;
      owner_n    = owner;
      last_n     = last;
      cnt_n      = cnt;
      accept     = 1'b0;
      ack        = '0;
      fifo_wrreq = 1'b0;
      fifo_data  = '0;

      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_n = ST_BURST;
               gnt_n   = pick_onehot;
               busy_n  = 1'b1;
               owner_n = pick_idx;
               cnt_n   = '0;
            end
         end
         ST_BURST: begin
            accept     = req[owner] & ~fifo_wrfull;
            fifo_wrreq = accept;
            fifo_data  = words[owner];
            ack[owner] = accept;
            // Owner abandoning the grant or the last word of a burst both release the port.
            if (!req[owner] || (accept && cnt == CNT_W'(MAX_BURST - 1))) begin
               state_n = ST_IDLE;
               gnt_n   = '0;
               busy_n  = 1'b0;
               last_n  = owner;
               cnt_n   = '0;
            end else if (accept) begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule
